// File: rtl/button_debounce.sv
// ============================================================================
// Module   : button_debounce
// Brief    : Per-channel input synchroniser and bounce filter for push
//            buttons. Optional held-key auto-repeat is enabled by defining
//            BUTTON_DEBOUNCE_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debounce #(
    parameter int N_BTN         = 5,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    ,
    parameter int REPEAT_DELAY  = 15000000,
    parameter int REPEAT_RATE   = 5000000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] push_raw,
    output logic [N_BTN-1:0] push_debounced
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    ,
    output logic [N_BTN-1:0] push_repeat
`endif
);

    localparam logic [1:0] c_ST_STABLE_LO = 2'd0;
    localparam logic [1:0] c_ST_WAIT_HI   = 2'd1;
    localparam logic [1:0] c_ST_STABLE_HI = 2'd2;
    localparam logic [1:0] c_ST_WAIT_LO   = 2'd3;

    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_REP_W   = $clog2(c_REP_MAX + 1);
    localparam logic [c_REP_W-1:0] c_REP_DELAY_LAST = c_REP_W'(REPEAT_DELAY - 1);
    localparam logic [c_REP_W-1:0] c_REP_RATE_LAST  = c_REP_W'(REPEAT_RATE - 1);
    localparam logic [c_REP_W-1:0] c_REP_ONE        = c_REP_W'(1);
`endif

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   w_s;
        logic [1:0]             r_state;
        logic [1:0]             w_state_nxt;
        logic [CNT_W-1:0]       r_cnt;
        logic [CNT_W-1:0]       w_cnt_nxt;
        logic                   r_deb;
        logic                   w_deb_nxt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], push_raw[i]};
            end
        end

        assign w_s = r_sync[SYNC_STAGES-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= c_ST_STABLE_LO;
                r_cnt   <= c_CNT_ZERO;
                r_deb   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_deb   <= w_deb_nxt;
            end
        end

        // Any return to the old level abandons the wait and restarts from zero.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = c_CNT_ZERO;
            case (r_state)
                c_ST_STABLE_LO: begin
                    if (w_s) begin
                        w_state_nxt = c_ST_WAIT_HI;
                        w_cnt_nxt   = c_CNT_ONE;
                    end
                end
                c_ST_WAIT_HI: begin
                    if (!w_s) begin
                        w_state_nxt = c_ST_STABLE_LO;
                    end else if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = c_ST_STABLE_HI;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_STABLE_HI: begin
                    if (!w_s) begin
                        w_state_nxt = c_ST_WAIT_LO;
                        w_cnt_nxt   = c_CNT_ONE;
                    end
                end
                c_ST_WAIT_LO: begin
                    if (w_s) begin
                        w_state_nxt = c_ST_STABLE_HI;
                    end else if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = c_ST_STABLE_LO;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_STABLE_LO;
                end
            endcase
        end

        // Output level follows the accepted level, held through the WAIT_LO window.
        always_comb begin
            w_deb_nxt = (w_state_nxt == c_ST_STABLE_HI) || (w_state_nxt == c_ST_WAIT_LO);
        end

        assign push_debounced[i] = r_deb;

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
        logic [c_REP_W-1:0] r_rep_cnt;
        logic               r_rep_phase;
        logic               r_rep_pulse;
        logic               w_rep_hold;
        logic [c_REP_W-1:0] w_rep_last;

        // Counting only while staying in STABLE_HI keeps the release edge pulse-free.
        assign w_rep_hold = (r_state == c_ST_STABLE_HI) && (w_state_nxt == c_ST_STABLE_HI);
        assign w_rep_last = r_rep_phase ? c_REP_RATE_LAST : c_REP_DELAY_LAST;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rep_cnt   <= '0;
                r_rep_phase <= 1'b0;
                r_rep_pulse <= 1'b0;
            end else if (!w_rep_hold) begin
                r_rep_cnt   <= '0;
                r_rep_phase <= 1'b0;
                r_rep_pulse <= 1'b0;
            end else if (r_rep_cnt == w_rep_last) begin
                r_rep_cnt   <= '0;
                r_rep_phase <= 1'b1;
                r_rep_pulse <= 1'b1;
            end else begin
                r_rep_cnt   <= r_rep_cnt + c_REP_ONE;
                r_rep_pulse <= 1'b0;
            end
        end

        assign push_repeat[i] = r_rep_pulse;
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_button_debounce.sv
// ============================================================================
// Module   : tb_button_debounce
// Brief    : Directed bench for button_debounce (2 channels, 2 sync stages,
//            8 stable cycles; repeat checks when BUTTON_DEBOUNCE_REPEAT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_debounce;

    localparam int N_BTN         = 2;
    localparam int SYNC_STAGES   = 2;
    localparam int STABLE_CYCLES = 8;
    localparam int LAT           = SYNC_STAGES + STABLE_CYCLES;

    logic             clk;
    logic             rst;
    logic [N_BTN-1:0] push_raw;
    logic [N_BTN-1:0] push_debounced;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    logic [N_BTN-1:0] push_repeat;
`endif

    int n_tests;
    int n_fail;

    button_debounce #(
        .N_BTN         (N_BTN),
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
        ,
        .REPEAT_DELAY  (20),
        .REPEAT_RATE   (6)
`endif
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .push_raw       (push_raw),
        .push_debounced (push_debounced)
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
        ,
        .push_repeat    (push_repeat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        rst      = 1'b1;
        push_raw = 2'b11;
        #1;
        n_tests++;
        if (push_debounced !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_async: got %b want 00", push_debounced);
        end
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
        n_tests++;
        if (push_repeat !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_repeat: got %b want 00", push_repeat);
        end
`endif
        tick(3);
        rst = 1'b0;
        tick(LAT - 1);
        n_tests++;
        if (push_debounced !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_early: got %b want 00 at edge 9", push_debounced);
        end
        tick(1);
        n_tests++;
        if (push_debounced !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_rise: got %b want 11 at edge 10", push_debounced);
        end
        push_raw = 2'b00;
        tick(LAT);
        n_tests++;
        if (push_debounced !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release: got %b want 00", push_debounced);
        end
    endtask

    task automatic test_clean_press;
        push_raw = 2'b01;
        tick(LAT - 1);
        n_tests++;
        if (push_debounced !== 2'b00) begin
            n_fail++;
            $display("FAIL press_edge9: got %b want 00", push_debounced);
        end
        tick(1);
        n_tests++;
        if (push_debounced !== 2'b01) begin
            n_fail++;
            $display("FAIL press_edge10: got %b want 01", push_debounced);
        end
        push_raw = 2'b00;
        tick(LAT);
        n_tests++;
        if (push_debounced !== 2'b00) begin
            n_fail++;
            $display("FAIL press_release: got %b want 00", push_debounced);
        end
    endtask

    task automatic test_bounce;
        int bad;
        bad = 0;
        for (int r = 0; r < 4; r++) begin
            push_raw = 2'b01;
            for (int k = 0; k < 3; k++) begin tick(1); if (push_debounced !== 2'b00) bad++; end
            push_raw = 2'b00;
            for (int k = 0; k < 2; k++) begin tick(1); if (push_debounced !== 2'b00) bad++; end
            push_raw = 2'b01;
            for (int k = 0; k < 5; k++) begin tick(1); if (push_debounced !== 2'b00) bad++; end
            push_raw = 2'b00;
            for (int k = 0; k < 2; k++) begin tick(1); if (push_debounced !== 2'b00) bad++; end
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL bounce_hold: %0d cycles with output high, want 0", bad);
        end
        push_raw = 2'b01;
        tick(LAT - 1);
        n_tests++;
        if (push_debounced !== 2'b00) begin
            n_fail++;
            $display("FAIL bounce_settle9: got %b want 00", push_debounced);
        end
        tick(1);
        n_tests++;
        if (push_debounced !== 2'b01) begin
            n_fail++;
            $display("FAIL bounce_settle10: got %b want 01", push_debounced);
        end
    endtask

    task automatic test_release;
        int bad;
        bad = 0;
        push_raw = 2'b00;
        for (int k = 0; k < 7; k++) begin tick(1); if (push_debounced !== 2'b01) bad++; end
        push_raw = 2'b01;
        for (int k = 0; k < 12; k++) begin tick(1); if (push_debounced !== 2'b01) bad++; end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL release_glitch: %0d cycles with output not 01", bad);
        end
        push_raw = 2'b00;
        tick(LAT - 1);
        n_tests++;
        if (push_debounced !== 2'b01) begin
            n_fail++;
            $display("FAIL release_edge9: got %b want 01", push_debounced);
        end
        tick(1);
        n_tests++;
        if (push_debounced !== 2'b00) begin
            n_fail++;
            $display("FAIL release_edge10: got %b want 00", push_debounced);
        end
    endtask

    task automatic test_reset_mid_wait;
        push_raw = 2'b01;
        tick(7);
        rst = 1'b1;
        #1;
        n_tests++;
        if (push_debounced !== 2'b00) begin
            n_fail++;
            $display("FAIL midrst_async: got %b want 00", push_debounced);
        end
        tick(2);
        rst = 1'b0;
        tick(LAT - 1);
        n_tests++;
        if (push_debounced !== 2'b00) begin
            n_fail++;
            $display("FAIL midrst_edge9: got %b want 00", push_debounced);
        end
        tick(1);
        n_tests++;
        if (push_debounced !== 2'b01) begin
            n_fail++;
            $display("FAIL midrst_edge10: got %b want 01", push_debounced);
        end
    endtask

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    task automatic test_repeat;
        logic exp;
        push_raw = 2'b00;
        tick(LAT);
        push_raw = 2'b01;
        tick(LAT);
        n_tests++;
        if (push_debounced !== 2'b01) begin
            n_fail++;
            $display("FAIL repeat_rise: got %b want 01", push_debounced);
        end
        for (int k = 1; k <= 45; k++) begin
            tick(1);
            exp = (k == 20) || (k == 26);
            n_tests++;
            if (push_repeat !== {1'b0, exp}) begin
                n_fail++;
                $display("FAIL repeat_k%0d: got %b want %b", k, push_repeat, {1'b0, exp});
            end
            if (k == 29) push_raw = 2'b00;
        end
    endtask
`endif

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b0;
        push_raw = 2'b00;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_reset_mid_wait();
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
        test_repeat();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
